// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared FSM state type, accumulator width and saturation limits
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  function automatic int acc_width(input int bw, input int k);
    return 2 * bw + $clog2(k * k);
  endfunction

  // Limits are returned as longint, so widths up to 63 bits are supported.
  function automatic longint sat_max(input int bw);
    return (longint'(1) <<< (bw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction

endpackage

// File: rtl/conv_stream_engine_if.sv
// rtl/conv_stream_engine_if.sv - pixel sink and result source handshakes of the conv engine
interface conv_stream_engine_if #(
  parameter int BITWIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_last;

  // slave: the engine side; master: the environment feeding pixels and taking results
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - ROWS full image rows of history; tap d is the pixel d+1 rows above
module conv_line_buffer #(
  parameter int BITWIDTH = 32,
  parameter int IMG_W    = 28,
  parameter int ROWS     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic signed [BITWIDTH-1:0] i_data,
  output logic signed [BITWIDTH-1:0] o_taps [ROWS]
);
  logic signed [BITWIDTH-1:0] r_sr [ROWS*IMG_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS * IMG_W; i++) r_sr[i] <= '0;
    end else if (i_push) begin
      r_sr[0] <= i_data;
      for (int i = 1; i < ROWS * IMG_W; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  // Read before the shift: the entry IMG_W-1 deep is the same column one row back.
  always_comb begin
    for (int d = 0; d < ROWS; d++) o_taps[d] = r_sr[(d+1)*IMG_W-1];
  end
endmodule

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - streaming KxK valid-convolution engine with saturating output
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_stream_engine
  import lenet_pkg::*;
#(
  parameter int BITWIDTH  = 32,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K         = 5,
  parameter int FRAC_BITS = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       k_we,
  input  logic [$clog2(K*K)-1:0]     k_addr,
  input  logic [BITWIDTH-1:0]        k_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  conv_stream_engine_if.slave        bus
);
  localparam int ACC_W = acc_width(BITWIDTH, K);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(BITWIDTH));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(BITWIDTH));

  conv_state_e                r_state, w_state_next;
  logic [COL_W-1:0]           r_col;
  logic [ROW_W-1:0]           r_row;
  logic signed [BITWIDTH-1:0] r_kern [K*K];
  logic signed [BITWIDTH-1:0] r_win  [K][K];
  logic signed [BITWIDTH-1:0] w_win  [K][K];
  logic signed [BITWIDTH-1:0] w_taps [K-1];
  logic signed [ACC_W-1:0]    w_acc, w_shift;
  logic signed [BITWIDTH-1:0] w_res;
  logic                       r_out_valid, r_out_last;
  logic [BITWIDTH-1:0]        r_out_data;
  logic                       w_accept, w_emit, w_last_pix, w_out_hs;

  assign bus.in_ready  = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_out_hs   = r_out_valid && bus.out_ready;
  assign w_last_pix = (r_col == COL_W'(IMG_W - 1)) && (r_row == ROW_W'(IMG_H - 1));
  assign w_emit     = (int'(r_row) >= K - 1) && (int'(r_col) >= K - 1);

  conv_line_buffer #(
    .BITWIDTH (BITWIDTH),
    .IMG_W    (IMG_W),
    .ROWS     (K - 1)
  ) u_line_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_accept),
    .i_data ($signed(bus.in_data)),
    .o_taps (w_taps)
  );

  // Window after this pixel: shift left, new right column from the line taps plus the pixel.
  always_comb begin
    w_win = r_win;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K - 1; j++) w_win[i][j] = r_win[i][j+1];
    for (int i = 0; i < K - 1; i++) w_win[i][K-1] = w_taps[K-2-i];
    w_win[K-1][K-1] = $signed(bus.in_data);
  end

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w_acc = w_acc + ACC_W'(w_win[i][j]) * ACC_W'(r_kern[i*K+j]);
    w_shift = w_acc >>> FRAC_BITS;
    if (w_shift > MAX_V)      w_res = MAX_V[BITWIDTH-1:0];
    else if (w_shift < MIN_V) w_res = MIN_V[BITWIDTH-1:0];
    else                      w_res = w_shift[BITWIDTH-1:0];
`ifdef CONV_RELU_EN
    if (w_res[BITWIDTH-1]) w_res = '0;
`else
    w_res = w_res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int k = 0; k < K * K; k++) r_kern[k] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) r_win[i][j] <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (r_col == COL_W'(IMG_W - 1)) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_accept) r_win <= w_win;
      if (k_we && r_state == ST_IDLE && int'(k_addr) < K * K) r_kern[k_addr] <= k_data;
      // A new result may land in the same cycle the old one is taken; the load wins.
      if (w_accept && w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_last  <= w_last_pix;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (w_accept && w_last_pix) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (w_out_hs && r_out_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end
endmodule
